// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: arithmetic unit op
// encodings, key codes and the sequencer state encoding.
package calc_pkg;

    // Operation codes understood by the arithmetic unit's op input.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;

    // Key codes: 0-9 are digits, KEY_OP_BASE+k selects op k (k = 0..6).
    localparam logic [4:0] KEY_OP_BASE = 5'd16;
    localparam logic [4:0] KEY_EQ      = 5'd23;
    localparam logic [4:0] KEY_CLR     = 5'd31;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_A    = 3'd0,  // entering operand A
        S_OP   = 3'd1,  // operator chosen, waiting for the first B digit
        S_B    = 3'd2,  // entering operand B
        S_LDB  = 3'd3,  // LoadB cycle
        S_WAIT = 3'd4,  // settle window of the combinational datapath
        S_RES  = 3'd5   // result shown, chaining possible
    } state_t;

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal entry register: builds an N-bit unsigned value one digit at a time
// (value*10 + digit) and refuses any digit that would overflow N bits.
module decimal_accumulator #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   digit,
    input  logic         load_first,
    input  logic         accumulate,
    input  logic         clear,
    output logic [N-1:0] value,
    output logic         overflow
);

    // value*10 + digit, evaluated with 4 guard bits so overflow is visible.
    logic [N+3:0] candidate;

    assign candidate = ({4'b0000, value} << 3) + ({4'b0000, value} << 1)
                     + {{N{1'b0}}, digit};

    // Any set guard bit means the new value would not fit in N bits.
    assign overflow = |candidate[N+3:N];

    // Digit register: clear wins, then a fresh first digit, then accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge values; a blocking = here would chain updates within a cycle.
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load_first) begin
            value <= {{(N-4){1'b0}}, digit};
        end else if (accumulate && !overflow) begin
            value <= candidate[N-1:0];
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-to-datapath sequencer: turns key strobes into operand loads for the
// arithmetic unit, waits out the settle window of its combinational
// multiplier/divider, captures the result and supports result chaining.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int N      = 32,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [4:0]   key_code,
    input  logic [N-1:0] result,
    output logic [N-1:0] operand,
    output logic         load_a,
    output logic         load_b,
    output logic         load_r,
    output logic [2:0]   op,
    output logic         arith_clear,
    output logic         busy,
    output logic [N-1:0] display,
    output logic         entry_full,
    output logic         div_zero
);

    localparam int CW = $clog2(SETTLE + 1);

    state_t          state;
    logic [CW-1:0]   settle_cnt;

    // Decoded key events; all but clear are suppressed while busy.
    logic            key_live;
    logic            is_digit;
    logic            is_op;
    logic            is_eq;
    logic            is_clr;
    logic            key_accepted;
    logic [3:0]      digit;
    logic [2:0]      key_op;

    // Accumulator controls and status.
    logic            a_first, a_acc, b_first, b_acc;
    logic            a_ovf, b_ovf;
    logic            digit_rejected;
    logic [N-1:0]    a_value, b_value;

    // Key decode and accumulator steering for the current state.
    always_comb begin
        // NOTE: every signal gets a default before the conditional logic so
        // no path leaves it unassigned, which would infer a latch.
        key_live       = 1'b0;
        is_digit       = 1'b0;
        is_op          = 1'b0;
        is_eq          = 1'b0;
        is_clr         = 1'b0;
        a_first        = 1'b0;
        a_acc          = 1'b0;
        b_first        = 1'b0;
        b_acc          = 1'b0;
        digit          = key_code[3:0];
        key_op         = key_code[2:0];

        key_live = key_valid && !busy;
        is_clr   = key_valid && (key_code == KEY_CLR);
        is_digit = key_live && (key_code <= 5'd9);
        is_op    = key_live && (key_code >= KEY_OP_BASE) && (key_code < KEY_EQ);
        is_eq    = key_live && (key_code == KEY_EQ);

        a_acc    = is_digit && (state == S_A);
        a_first  = is_digit && (state == S_RES);
        b_first  = is_digit && (state == S_OP);
        b_acc    = is_digit && (state == S_B);

        key_accepted   = is_digit || is_op || is_eq;
        digit_rejected = (a_acc && a_ovf) || (b_acc && b_ovf);
    end

    decimal_accumulator #(.N(N)) u_acc_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit      (digit),
        .load_first (a_first),
        .accumulate (a_acc),
        .clear      (is_clr),
        .value      (a_value),
        .overflow   (a_ovf)
    );

    decimal_accumulator #(.N(N)) u_acc_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit      (digit),
        .load_first (b_first),
        .accumulate (b_acc),
        .clear      (is_clr),
        .value      (b_value),
        .overflow   (b_ovf)
    );

    // Sequencer FSM with registered load pulses, operand bus, flags and display.
    // Load pulses are raised on the edge that enters the state they belong to,
    // so Operand is set on that same edge and is stable for the whole pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_A;
            settle_cnt  <= '0;
            operand     <= '0;
            load_a      <= 1'b0;
            load_b      <= 1'b0;
            load_r      <= 1'b0;
            op          <= '0;
            arith_clear <= 1'b0;
            busy        <= 1'b0;
            display     <= '0;
            entry_full  <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            load_a      <= 1'b0;
            load_b      <= 1'b0;
            load_r      <= 1'b0;
            arith_clear <= 1'b0;

            // Display follows the state one register stage later.
            case (state)
                S_B, S_WAIT: display <= b_value;
                S_RES:       display <= result;
                default:     display <= a_value;
            endcase

            if (is_clr) begin
                // Clear aborts anything in flight, including a pending LoadR.
                arith_clear <= 1'b1;
                op          <= '0;
                entry_full  <= 1'b0;
                div_zero    <= 1'b0;
                busy        <= 1'b0;
                settle_cnt  <= '0;
                state       <= S_A;
            end else begin
                if (key_accepted) begin
                    entry_full <= digit_rejected;
                end

                case (state)
                    S_A: begin
                        if (is_op) begin
                            operand <= a_value;
                            load_a  <= 1'b1;
                            op      <= key_op;
                            state   <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (is_op) begin
                            op <= key_op;
                        end else if (is_digit) begin
                            state <= S_B;
                        end
                    end
                    S_B: begin
                        if (is_op) begin
                            op <= key_op;
                        end else if (is_eq) begin
                            operand <= b_value;
                            load_b  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= S_LDB;
                            if ((op == OP_DIV) && (b_value == '0)) begin
                                div_zero <= 1'b1;
                            end
                        end
                    end
                    S_LDB: begin
                        settle_cnt <= CW'(SETTLE);
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Counter reaching zero raises LoadR; the following
                        // edge ends the compute and enters S_RES.
                        if (settle_cnt != '0) begin
                            settle_cnt <= settle_cnt - 1'b1;
                            if (settle_cnt == CW'(1)) begin
                                load_r <= 1'b1;
                            end
                        end else begin
                            busy  <= 1'b0;
                            state <= S_RES;
                        end
                    end
                    S_RES: begin
                        if (is_op) begin
                            operand <= result;
                            load_a  <= 1'b1;
                            op      <= key_op;
                            state   <= S_OP;
                        end else if (is_digit) begin
                            state <= S_A;
                        end
                    end
                    default: begin
                        state <= S_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: a behavioural arithmetic unit drives
// Result, a scoreboard queue holds the expected load/clear pulses, and a
// negedge monitor pops and compares each pulse as the DUT produces it.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int N      = 8;
    localparam int SETTLE = 4;

    localparam int K_NONE = 0;
    localparam int K_LDA  = 1;
    localparam int K_LDB  = 2;
    localparam int K_LDR  = 3;
    localparam int K_ACLR = 4;

    typedef struct {
        int          kind;
        logic [N-1:0] operand;
        logic [2:0]  op;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [4:0]   key_code;
    logic [N-1:0] result;
    logic [N-1:0] operand;
    logic         load_a, load_b, load_r;
    logic [2:0]   op;
    logic         arith_clear;
    logic         busy;
    logic [N-1:0] display;
    logic         entry_full;
    logic         div_zero;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    // Monitor bookkeeping.
    exp_t e;
    int   got_kind;
    int   cyc_lda, cyc_ldb, cyc_ldr;
    logic busy_at_ldb, busy_at_ldr, dz_at_ldb;

    // Behavioural arithmetic unit registers.
    logic [N-1:0] ra, rb, rr;

    calc_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .result      (result),
        .operand     (operand),
        .load_a      (load_a),
        .load_b      (load_b),
        .load_r      (load_r),
        .op          (op),
        .arith_clear (arith_clear),
        .busy        (busy),
        .display     (display),
        .entry_full  (entry_full),
        .div_zero    (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] f);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == '0) ? '1 : a / b;
            3'd4:    return a << b[2:0];
            3'd5:    return a >> b[2:0];
            3'd6:    return $signed(a) >>> b[2:0];
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
            rr <= '0;
        end else if (arith_clear) begin
            ra <= '0;
            rb <= '0;
            rr <= '0;
        end else begin
            if (load_a) ra <= operand;
            if (load_b) rb <= operand;
            if (load_r) rr <= alu(ra, rb, op);
        end
    end
    assign result = rr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_pulse(input int kind, input logic [N-1:0] opnd, input logic [2:0] o);
        exp_t x;
        x.kind    = kind;
        x.operand = opnd;
        x.op      = o;
        sb.push_back(x);
    endtask

    task automatic press(input logic [4:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ldr(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (load_r) begin
                seen = 1'b1;
                break;
            end
        end
        check("ldr_arrives", 32'(seen), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {operand, load_a, load_b, load_r, op, arith_clear, busy,
                    display, entry_full, div_zero}, 32'd0);
    endtask

    // Scoreboard monitor: every load/clear pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && (load_a || load_b || load_r || arith_clear)) begin
            got_kind = arith_clear ? K_ACLR : load_a ? K_LDA : load_b ? K_LDB : K_LDR;
            check("pulse_onehot", 32'(load_a) + 32'(load_b) + 32'(load_r) + 32'(arith_clear), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(got_kind), 32'(K_NONE));
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'(got_kind), 32'(e.kind));
                if (e.kind != K_ACLR) begin
                    check("pulse_operand", 32'(operand), 32'(e.operand));
                    check("pulse_op", 32'(op), 32'(e.op));
                end
            end
            if (load_a) cyc_lda = cyc;
            if (load_b) begin
                cyc_ldb     = cyc;
                busy_at_ldb = busy;
                dz_at_ldb   = div_zero;
            end
            if (load_r) begin
                cyc_ldr     = cyc;
                busy_at_ldr = busy;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        idle(3);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        idle(2);
        check_outputs_zero("post_reset_outputs");

        // 12 + 34 = 46 with timing of LoadA / LoadB / LoadR.
        expect_pulse(K_LDA, 8'd12, 3'd0);
        expect_pulse(K_LDB, 8'd34, 3'd0);
        expect_pulse(K_LDR, 8'd34, 3'd0);
        press(5'd1); press(5'd2); press(5'd16); press(5'd3); press(5'd4); press(5'd23);
        wait_ldr(20);
        idle(3);
        check("lda_to_ldb_gap", 32'(cyc_ldb - cyc_lda), 32'd3);
        check("ldb_to_ldr_gap", 32'(cyc_ldr - cyc_ldb), 32'(SETTLE + 1));
        check("busy_at_ldb", 32'(busy_at_ldb), 32'd1);
        check("busy_at_ldr", 32'(busy_at_ldr), 32'd1);
        check("add_display", 32'(display), 32'd46);
        check("add_busy_low", 32'(busy), 32'd0);

        // Chaining: 7 * 6 = 42, then - 2 = 40 reusing Result as A.
        expect_pulse(K_ACLR, '0, 3'd0);
        press(5'd31);
        expect_pulse(K_LDA, 8'd7, 3'd2);
        expect_pulse(K_LDB, 8'd6, 3'd2);
        expect_pulse(K_LDR, 8'd6, 3'd2);
        press(5'd7); press(5'd18); press(5'd6); press(5'd23);
        wait_ldr(20);
        idle(3);
        check("mul_display", 32'(display), 32'd42);
        expect_pulse(K_LDA, 8'd42, 3'd1);
        expect_pulse(K_LDB, 8'd2, 3'd1);
        expect_pulse(K_LDR, 8'd2, 3'd1);
        press(5'd17); press(5'd2); press(5'd23);
        wait_ldr(20);
        idle(3);
        check("chain_display", 32'(display), 32'd40);
        check("chain_op", 32'(op), 32'd1);

        // Entry overflow at N=8: 2,5,5 fits, 9 is rejected.
        expect_pulse(K_ACLR, '0, 3'd0);
        press(5'd31);
        press(5'd2); press(5'd5); press(5'd5); press(5'd9);
        idle(2);
        check("ovf_display", 32'(display), 32'd255);
        check("ovf_entry_full", 32'(entry_full), 32'd1);
        expect_pulse(K_LDA, 8'd255, 3'd0);
        press(5'd16);
        idle(1);
        check("ovf_cleared_by_key", 32'(entry_full), 32'd0);
        press(5'd3);
        idle(2);
        check("ovf_b_display", 32'(display), 32'd3);
        check("ovf_b_entry_full", 32'(entry_full), 32'd0);
        expect_pulse(K_ACLR, '0, 3'd0);
        press(5'd31);
        idle(2);
        check("clr_display", 32'(display), 32'd0);

        // Divide by zero: sticky flag, compute still runs, clear drops it.
        expect_pulse(K_LDA, 8'd9, 3'd3);
        expect_pulse(K_LDB, 8'd0, 3'd3);
        expect_pulse(K_LDR, 8'd0, 3'd3);
        press(5'd9); press(5'd19); press(5'd0);
        check("dz_before_eq", 32'(div_zero), 32'd0);
        press(5'd23);
        wait_ldr(20);
        check("dz_at_ldb", 32'(dz_at_ldb), 32'd1);
        check("dz_sticky", 32'(div_zero), 32'd1);
        idle(3);
        check("div_display", 32'(display), 32'hFF);
        expect_pulse(K_ACLR, '0, 3'd0);
        press(5'd31);
        idle(1);
        check("dz_cleared", 32'(div_zero), 32'd0);

        // Keys during the settle window are dropped; clear aborts the compute.
        expect_pulse(K_LDA, 8'd8, 3'd0);
        expect_pulse(K_LDB, 8'd1, 3'd0);
        press(5'd8); press(5'd16); press(5'd1); press(5'd23);
        idle(2);
        press(5'd5); press(5'd16);
        check("wait_display", 32'(display), 32'd1);
        check("wait_busy", 32'(busy), 32'd1);
        expect_pulse(K_ACLR, '0, 3'd0);
        press(5'd31);
        idle(8);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_display", 32'(display), 32'd0);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // State is S_A again: a new A entry loads; then reset mid-settle.
        expect_pulse(K_LDA, 8'd3, 3'd0);
        expect_pulse(K_LDB, 8'd4, 3'd0);
        press(5'd3); press(5'd16); press(5'd4); press(5'd23);
        idle(3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midwait_reset_outputs");
        check("midwait_sb_empty", 32'(sb.size()), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("post_reset_busy", 32'(busy), 32'd0);
        expect_pulse(K_LDA, 8'd3, 3'd0);
        expect_pulse(K_LDB, 8'd4, 3'd0);
        expect_pulse(K_LDR, 8'd4, 3'd0);
        press(5'd3); press(5'd16); press(5'd4); press(5'd23);
        wait_ldr(20);
        idle(3);
        check("fresh_display", 32'(display), 32'd7);
        check("fresh_busy", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
